// File: rtl/if_stage.sv
// if_stage: instruction fetch; PC generation, single-outstanding inst SRAM port,
// one-entry FULL buffer toward decode, branch redirect with in-flight squash.
// Ports: clk, reset (async, active-high), ds_allowin, br_bus{taken,target},
//   fs_to_ds_valid, fs_to_ds_bus{pc,inst}, inst_sram_{req,addr,addr_ok,data_ok,rdata}.
// Build option FS_PERF_CNT_EN: adds fs_fetch_cnt / fs_cancel_cnt counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic [32:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
`ifdef FS_PERF_CNT_EN
  ,
  output logic [31:0] fs_fetch_cnt,
  output logic [31:0] fs_cancel_cnt
`endif
);

  typedef enum logic [1:0] {
    FS_EMPTY = 2'd0,
    FS_WAIT  = 2'd1,
    FS_FULL  = 2'd2
  } fs_state_e;

  fs_state_e   fs_state_q;
  fs_state_e   fs_state_d;
  logic [31:0] pf_pc_q;
  logic [31:0] pf_pc_d;
  logic [31:0] fs_pc_q;
  logic [31:0] fs_pc_d;
  logic [31:0] fs_inst_q;
  logic [31:0] fs_inst_d;
  logic        cancel_q;
  logic        cancel_d;

  logic        br_taken;
  logic [31:0] br_target;
  logic        br_evt;
  logic        st_empty;
  logic        st_wait;
  logic        st_full;
  logic        outstanding;
  logic        addr_hs;
  logic        handoff;

  assign br_taken  = br_bus[32];
  assign br_target = br_bus[31:0];

  // The branch leaves decode exactly when decode accepts the next slot.
  assign br_evt = br_taken && ds_allowin;

  assign st_empty = (fs_state_q == FS_EMPTY);
  assign st_wait  = (fs_state_q == FS_WAIT);
  assign st_full  = (fs_state_q == FS_FULL);

  // A cancelled response still occupies the port until it returns.
  assign outstanding = st_wait || cancel_q;

  assign inst_sram_req  = !reset && !br_taken && !outstanding &&
                          (st_empty || (st_full && ds_allowin));
  assign inst_sram_addr = pf_pc_q;

  assign addr_hs = inst_sram_req && inst_sram_addr_ok;
  assign handoff = st_full && ds_allowin && !br_taken;

  assign fs_to_ds_valid = st_full && !br_taken;
  assign fs_to_ds_bus   = {fs_pc_q, fs_inst_q};

  always_comb begin
    pf_pc_d    = pf_pc_q;
    fs_state_d = fs_state_q;
    fs_pc_d    = fs_pc_q;
    fs_inst_d  = fs_inst_q;
    cancel_d   = cancel_q;

    // Squashed response returns: drop it, state is already EMPTY.
    if (cancel_q && inst_sram_data_ok) begin
      cancel_d = 1'b0;
    end

    if (br_evt) begin
      pf_pc_d    = br_target;
      fs_state_d = FS_EMPTY;
      // A coincident data_ok is simply discarded; only a still
      // pending response needs to be remembered and squashed.
      if (st_wait && !inst_sram_data_ok) begin
        cancel_d = 1'b1;
      end
    end else begin
      if (addr_hs) begin
        pf_pc_d = pf_pc_q + 32'd4;
        fs_pc_d = pf_pc_q;
      end
      case (fs_state_q)
        FS_EMPTY: begin
          if (addr_hs) begin
            fs_state_d = FS_WAIT;
          end
        end
        FS_WAIT: begin
          // Lands even while a branch waits in decode; it is
          // dropped later at the branch event.
          if (inst_sram_data_ok) begin
            fs_inst_d  = inst_sram_rdata;
            fs_state_d = FS_FULL;
          end
        end
        FS_FULL: begin
          if (handoff) begin
            fs_state_d = addr_hs ? FS_WAIT : FS_EMPTY;
          end
        end
        default: begin
          fs_state_d = FS_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_state_q <= FS_EMPTY;
      pf_pc_q    <= RESET_PC;
      fs_pc_q    <= 32'd0;
      fs_inst_q  <= 32'd0;
      cancel_q   <= 1'b0;
    end else begin
      fs_state_q <= fs_state_d;
      pf_pc_q    <= pf_pc_d;
      fs_pc_q    <= fs_pc_d;
      fs_inst_q  <= fs_inst_d;
      cancel_q   <= cancel_d;
    end
  end

`ifdef FS_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] fetch_cnt_d;
  logic [31:0] cancel_cnt_q;
  logic [31:0] cancel_cnt_d;
  logic        discard;

  // These sources are mutually exclusive: cancel only lives in EMPTY.
  assign discard = (cancel_q && inst_sram_data_ok) ||
                   (br_evt && st_full) ||
                   (br_evt && st_wait && inst_sram_data_ok);

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    cancel_cnt_d = cancel_cnt_q;
    if (handoff) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (discard) begin
      cancel_cnt_d = cancel_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q  <= 32'd0;
      cancel_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      cancel_cnt_q <= cancel_cnt_d;
    end
  end

  assign fs_fetch_cnt  = fetch_cnt_q;
  assign fs_cancel_cnt = cancel_cnt_q;
`endif

endmodule
